// File: rtl/instr_fetch.sv
`default_nettype none
// instr_fetch: single-outstanding instruction fetch with a PC/instruction FIFO toward decode.
// Define INSTR_FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module instr_fetch #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_stall,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          if_valid,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          if_ready
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] instr_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q    [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_REQ;
      S_REQ: begin
        if (mem_gnt)    state_d = flush ? S_DRAIN : S_WAIT;
        else if (flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (mem_rvalid) state_d = S_IDLE;
        else if (flush) state_d = S_DRAIN;
      end
      S_DRAIN: if (mem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; FIFO space is reserved at accept, so push can never overflow.
  always_comb begin
    pc_stall = flush | (state_q != S_IDLE) | (count_q == CW'(DEPTH));
    mem_req  = (state_q == S_REQ);
    push     = (state_q == S_WAIT) & mem_rvalid & ~flush;
  end

  assign accept   = pc_valid & ~pc_stall;
  assign if_valid = (count_q != '0);
  assign pop      = if_valid & if_ready & ~flush;
  assign mem_addr = addr_q;
  assign if_instr = instr_mem_q[rd_ptr_q];
  assign if_pc    = pc_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (flush)             count_d = '0;
    else if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (accept) addr_q <= pc_in;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= mem_rdata;
      pc_mem_q[wr_ptr_q]    <= addr_q;
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;

  // Only flushes that actually discard work are counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (flush && ((state_q != S_IDLE) || (count_q != '0)))
        perf_flushed_q <= perf_flushed_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// Self-checking bench for instr_fetch: vector table, directed corner sequences, random vs. reference model.
module tb_instr_fetch;
  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_in;
  logic          pc_valid;
  logic          pc_stall;
  logic          flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          if_ready;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_flushed;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_stall(pc_stall),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
`ifdef INSTR_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: abstract fetch bookkeeping plus a queue of delivered instructions.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  bit          m_pend;   // address accepted, not yet granted
  bit          m_infl;   // granted, response still to come
  bit          m_disc;   // response of the in-flight read must be dropped
  logic [31:0] m_addr;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_pend    = 1'b0;
    m_infl    = 1'b0;
    m_disc    = 1'b0;
    m_addr    = '0;
    m_fetched = '0;
    m_flushed = '0;
  endtask

  // Apply one cycle of inputs (at negedge) and compare outputs with the model.
  task automatic drive(input bit pv, input logic [31:0] pc, input bit fl, input bit gnt,
                       input bit rv, input logic [31:0] rd, input bit rdy);
    pc_valid   = pv;
    pc_in      = pc;
    flush      = fl;
    mem_gnt    = gnt;
    mem_rvalid = rv;
    mem_rdata  = rd;
    if_ready   = rdy;
    #1;
    chk("pc_stall", 32'(pc_stall), 32'(fl || m_pend || m_infl || (m_q.size() == DEPTH)));
    chk("mem_req", 32'(mem_req), 32'(m_pend));
    chk("mem_addr", mem_addr, m_addr);
    chk("if_valid", 32'(if_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("if_pc", if_pc, m_q[0].pc);
      chk("if_instr", if_instr, m_q[0].instr);
    end
`ifdef INSTR_FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushed", perf_flushed, m_flushed);
`endif
  endtask

  // Cross the rising edge and update the model from the inputs presented this cycle.
  task automatic advance();
    bit stall;
    bit pop;
    int sz;
    sz    = m_q.size();
    stall = flush || m_pend || m_infl || (sz == DEPTH);
    pop   = (sz != 0) && if_ready;
    @(posedge clk);
    if (flush) begin
      if (m_pend || m_infl || sz != 0) m_flushed++;
      if (m_pend) begin
        if (mem_gnt) begin
          m_infl = 1'b1;
          m_disc = 1'b1;
        end
        m_pend = 1'b0;
      end else if (m_infl) begin
        if (mem_rvalid) m_infl = 1'b0;
        else            m_disc = 1'b1;
      end
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_pend && mem_gnt) begin
        m_pend = 1'b0;
        m_infl = 1'b1;
        m_disc = 1'b0;
      end else if (m_infl && mem_rvalid) begin
        m_infl = 1'b0;
        if (!m_disc) begin
          m_q.push_back('{pc: m_addr, instr: mem_rdata});
          m_fetched++;
        end
        m_disc = 1'b0;
      end
      if (pc_valid && !stall) begin
        m_pend = 1'b1;
        m_addr = pc_in;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    pc_valid = 0; pc_in = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; if_ready = 0;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Accept, grant next cycle, data the cycle after: zero-wait memory.
  task automatic fetch_zero(input logic [31:0] pc, input logic [31:0] data, input bit rdy);
    drive(1, pc, 0, 0, 0, 0, rdy); advance();
    drive(0, 0, 0, 1, 0, 0, rdy);  advance();
    drive(0, 0, 0, 0, 1, data, rdy); advance();
  endtask

  typedef struct {
    bit          pv;
    logic [31:0] pc;
    bit          fl;
    bit          gnt;
    bit          rv;
    logic [31:0] rd;
    bit          rdy;
    bit          e_stall;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_v;
    bit          chk_head;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt[7];
  int   lat;

  initial begin
    // pv pc fl gnt rv rd rdy | stall req addr v chk pc instr
    vt[0] = '{1, 32'h10, 0, 0, 0, 0,            0, 0, 0, 32'h0,  0, 0, 0, 0};
    vt[1] = '{1, 32'h11, 0, 1, 0, 0,            0, 1, 1, 32'h10, 0, 0, 0, 0};
    vt[2] = '{1, 32'h11, 0, 0, 1, 32'h8C010004, 0, 1, 0, 32'h10, 0, 0, 0, 0};
    vt[3] = '{1, 32'h11, 0, 0, 0, 0,            0, 0, 0, 32'h10, 1, 1, 32'h10, 32'h8C010004};
    vt[4] = '{1, 32'h12, 0, 0, 0, 0,            1, 1, 1, 32'h11, 1, 1, 32'h10, 32'h8C010004};
    vt[5] = '{1, 32'h12, 1, 0, 0, 0,            0, 1, 1, 32'h11, 0, 0, 0, 0};
    vt[6] = '{0, 32'h0,  0, 0, 0, 0,            0, 0, 0, 32'h11, 0, 0, 0, 0};

    pc_valid = 0; pc_in = 0; flush = 1; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; if_ready = 0;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    #1;
    chk("rst_stall_flush", 32'(pc_stall), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    flush = 0;
    #1;
    chk("rst_stall_noflush", 32'(pc_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic fetch then withdrawal of an ungranted request.
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].pv, vt[i].pc, vt[i].fl, vt[i].gnt, vt[i].rv, vt[i].rd, vt[i].rdy);
      chk($sformatf("vec%0d_stall", i), 32'(pc_stall), 32'(vt[i].e_stall));
      chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vt[i].e_req));
      chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vt[i].e_v));
      if (vt[i].chk_head) begin
        chk($sformatf("vec%0d_pc", i), if_pc, vt[i].e_pc);
        chk($sformatf("vec%0d_instr", i), if_instr, vt[i].e_instr);
      end
      advance();
    end

    // FIFO full back-pressure, pop, then simultaneous push and pop at count 1.
    do_reset();
    fetch_zero(32'h0, 32'hA0000000, 0);
    fetch_zero(32'h1, 32'hA0000001, 0);
    drive(1, 32'h2, 0, 0, 0, 0, 0);
    chk("full_stall", 32'(pc_stall), 32'd1);
    advance();
    drive(1, 32'h2, 0, 0, 0, 0, 1); advance();
    drive(1, 32'h2, 0, 0, 0, 0, 0);
    chk("accept_after_pop", 32'(pc_stall), 32'd0);
    advance();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("req_after_accept", 32'(mem_req), 32'd1);
    chk("req_addr", mem_addr, 32'h2);
    advance();
    drive(0, 0, 0, 0, 1, 32'hA0000002, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 1); advance();
    drive(1, 32'h3, 0, 0, 0, 0, 0); advance();
    drive(0, 0, 0, 1, 0, 0, 0); advance();
    drive(0, 0, 0, 0, 1, 32'hA0000003, 1); advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pushpop_valid", 32'(if_valid), 32'd1);
    chk("pushpop_head", if_pc, 32'h3);
    chk("pushpop_instr", if_instr, 32'hA0000003);
    advance();

    // Flush while waiting for data; late response must be discarded.
    do_reset();
    drive(1, 32'h20, 0, 0, 0, 0, 1); advance();
    drive(0, 0, 0, 1, 0, 0, 1); advance();
    drive(0, 0, 1, 0, 0, 0, 1); advance();
    drive(1, 32'h21, 0, 0, 0, 0, 1);
    chk("drain_stall", 32'(pc_stall), 32'd1);
    advance();
    drive(1, 32'h21, 0, 0, 1, 32'hDEADBEEF, 1); advance();
    drive(1, 32'h21, 0, 0, 0, 0, 0);
    chk("drain_if_valid", 32'(if_valid), 32'd0);
    chk("drain_accept", 32'(pc_stall), 32'd0);
    advance();

    // Asynchronous reset while a read is outstanding.
    do_reset();
    fetch_zero(32'h30, 32'h11112222, 0);
    drive(1, 32'h31, 0, 0, 0, 0, 0); advance();
    drive(0, 0, 0, 1, 0, 0, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_req", 32'(mem_req), 32'd0);
    chk("async_mem_addr", mem_addr, 32'd0);
    chk("async_if_valid", 32'(if_valid), 32'd0);
    chk("async_if_pc", if_pc, 32'd0);
    chk("async_if_instr", if_instr, 32'd0);
    chk("async_stall", 32'(pc_stall), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;

`ifdef INSTR_FETCH_PERF_EN
    do_reset();
    for (int i = 0; i < 5; i++) fetch_zero(32'h40 + 32'(i), 32'h5000 + 32'(i), 1);
    drive(1, 32'h45, 0, 0, 0, 0, 1); advance();
    drive(0, 0, 0, 1, 0, 0, 1); advance();
    drive(0, 0, 1, 0, 0, 0, 1); advance();
    drive(0, 0, 0, 0, 1, 32'hDEADBEEF, 1); advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("perf_fetched_5", perf_fetched, 32'd5);
    chk("perf_flushed_1", perf_flushed, 32'd1);
    advance();
`endif

    // Random traffic against the reference model.
    do_reset();
    lat = 0;
    for (int i = 0; i < 4000; i++) begin
      bit pv;
      bit fl;
      bit gnt;
      bit rv;
      bit rdy;
      pv  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      gnt = m_pend && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = 1'b0;
      if (m_infl) begin
        rv = (lat == 0);
        if (lat > 0) lat--;
      end else if (!m_pend) begin
        rv = ($urandom_range(0, 15) == 0);
      end
      drive(pv, $urandom, fl, gnt, rv, $urandom, rdy);
      if (gnt) lat = $urandom_range(0, 2);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
